filter_frame_scheduler: RTL and testbench
=========================================

Name: filter_frame_scheduler

Overview:
- Frame-synchronous controller for the VGA convolution filter datapath.
- Owns the filter mode select and the active 3x3 custom kernel coefficients.
- Changes both only at vertical-sync frame boundaries, so a frame is never rendered with mixed modes or half-updated coefficients.
- Optional auto-cycle demo mode steps through filter modes every N frames.
- Sits between user inputs (switch/key decode) and the filter output mux / mutable kernel instances.

Parameters:
- NUM_MODES, 15: number of valid filter modes (0..NUM_MODES-1).
- PRECISION, 16: coefficient width, signed two's complement.
- FRAMES_PER_MODE, 60: frames per mode step in auto-cycle; legal range 1..255.

Ports:
- VGA_CLK  in  1  25 MHz pixel clock.
- reset  in  1  synchronous, active-high.
- iVGA_VS  in  1  vertical sync, low between frames.
- mode_req  in  4  requested filter mode.
- auto_en  in  1  1 = auto-cycle modes.
- coef_wr  in  1  write coef_val into shadow bank entry coef_idx.
- coef_idx  in  4  row*3+col, 0..8.
- coef_val  in  PRECISION  signed coefficient.
- coef_commit  in  1  request shadow->active kernel transfer at next frame start.
- mode_sel  out  4  active filter mode.
- kernel  out  [2:0][2:0] x PRECISION  active coefficients; kernel[r][c] = shadow entry r*3+c.
- coef_busy  out  1  commit pending (shadow locked).
- swap_pulse  out  1  one-cycle strobe when kernel and/or mode_sel update.
- coef_err  out  1  one-cycle strobe on a rejected write.

Behaviour:
- Reset:
  - mode_sel=0; all kernel and shadow entries=0; coef_busy=0; swap_pulse=0; coef_err=0.
  - Frame counter=0; state=IDLE; VS history register=1 (no false edge after reset).
- Frame start:
  - iVGA_VS is registered once (vs_q), then again (vs_qq).
  - fs = vs_qq & ~vs_q, i.e. fs asserts 2 cycles after VS falls at the pin.
  - All updates (mode_sel, kernel, swap_pulse) are registered in the cycle after fs.
- Mode select, evaluated at each fs:
  - auto_en=0: mode_sel <= (mode_req < NUM_MODES) ? mode_req : 0; frame counter <= 0.
  - auto_en=1: frame counter increments.
  - When the counter reaches FRAMES_PER_MODE-1: counter <= 0 and mode_sel <= mode_sel+1, wrapping NUM_MODES-1 -> 0.
  - auto_en 0->1 starts counting from the current mode_sel. 1->0 loads mode_req at the next fs.
  - swap_pulse asserts only if mode_sel or kernel actually changes.
- Coefficient FSM, states IDLE, PENDING:
  - IDLE:
    - coef_wr with coef_idx<=8 writes the shadow entry next cycle.
    - coef_idx 9..15: no write, coef_err pulses.
    - coef_commit -> PENDING, coef_busy=1 next cycle.
  - IDLE, same cycle coef_wr + coef_commit: the write lands and is included in the commit.
  - PENDING:
    - coef_wr rejected: shadow unchanged, coef_err pulses.
    - coef_commit ignored.
    - On fs: active kernel <= shadow (all 9 entries in one cycle), swap_pulse=1, -> IDLE, coef_busy=0.
  - Commit asserted in the same cycle as fs: the FSM is still IDLE, so the transfer occurs at the following fs. This guarantees at least one full frame of lead time.
- Active kernel is never modified except at a PENDING fs or reset. The shadow is never cleared except by reset.
- Reset mid-PENDING: abandon the commit. The active kernel goes to 0 with no swap_pulse.
- Arithmetic:
  - Coefficients are stored and forwarded unmodified; no saturation.
  - Frame counter is 8 bits.
  - Mode increment is 4-bit compare against NUM_MODES-1, not natural overflow.

Test Plan:
- Reset, then VS toggling at 20-cycle low / 200-cycle high, mode_req=5, auto_en=0 -> mode_sel=0 until first fs, =5 at fs+1, swap_pulse one cycle.
- Write idx4=8 and idx0..3,5..8=-1, commit mid-frame -> coef_busy=1 immediately. kernel stays 0 until next fs, then kernel[1][1]=8, the others 16'hFFFF; swap_pulse=1; coef_busy=0.
- During PENDING, write idx0=3 -> coef_err pulse; the committed kernel[0][0] stays -1. Then write idx9 in IDLE -> coef_err, shadow unchanged.
- FRAMES_PER_MODE=2, NUM_MODES=15, auto_en=1 from mode 13 -> 13,13,14,14,0 across 5 frames; wrap verified.
- coef_commit coincident with the fs cycle -> no transfer at that fs; transfer at the next fs.
- mode_req=15 with NUM_MODES=15 -> mode_sel=0. Reset asserted during PENDING -> kernel all 0, coef_busy=0, no swap_pulse.

Source files
------------

// File: rtl/filter_frame_scheduler.sv
// filter_frame_scheduler: owns the filter mode and the 3x3 kernel for the VGA filter datapath,
// double-buffering both so that every change lands just after vertical sync falls.
module filter_frame_scheduler #(
    parameter int NUM_MODES       = 15,
    parameter int PRECISION       = 16,
    parameter int FRAMES_PER_MODE = 60
) (
    input  logic                           VGA_CLK,
    input  logic                           reset,
    input  logic                           iVGA_VS,
    input  logic [3:0]                     mode_req,
    input  logic                           auto_en,
    input  logic                           coef_wr,
    input  logic [3:0]                     coef_idx,
    input  logic [PRECISION-1:0]           coef_val,
    input  logic                           coef_commit,
    output logic [3:0]                     mode_sel,
    output logic [2:0][2:0][PRECISION-1:0] kernel,
    output logic                           coef_busy,
    output logic                           swap_pulse,
    output logic                           coef_err
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;
    localparam logic [4:0] MODE_COUNT = 5'(NUM_MODES);
    localparam logic [3:0] MODE_LAST  = 4'(NUM_MODES - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_MODE - 1);

    logic                           vs_q, vs_qq, fs;
    logic [0:0]                     state;
    logic [7:0]                     frame_cnt, frame_cnt_next;
    logic [3:0]                     mode_next, mode_step;
    logic [2:0][2:0][PRECISION-1:0] shadow;
    logic                           wr_ok, kernel_swap, frame_wrap;

    assign fs          = vs_qq & ~vs_q;
    assign coef_busy   = state == PENDING;
    assign wr_ok       = coef_wr & ~coef_busy & (coef_idx <= 4'd8);
    assign kernel_swap = fs & coef_busy;
    assign frame_wrap  = frame_cnt == FRAME_LAST;

    always_comb begin
        mode_step      = (mode_sel == MODE_LAST) ? 4'd0 : mode_sel + 4'd1;
        mode_next      = auto_en ? (frame_wrap ? mode_step : mode_sel)
                                 : (({1'b0, mode_req} < MODE_COUNT) ? mode_req : 4'd0);
        frame_cnt_next = (auto_en & ~frame_wrap) ? frame_cnt + 8'd1 : 8'd0;
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            vs_q       <= 1'b1;
            vs_qq      <= 1'b1;
            state      <= IDLE;
            frame_cnt  <= 8'd0;
            mode_sel   <= 4'd0;
            shadow     <= '0;
            kernel     <= '0;
            swap_pulse <= 1'b0;
            coef_err   <= 1'b0;
        end else begin
            vs_q       <= iVGA_VS;
            vs_qq      <= vs_q;
            coef_err   <= coef_wr & (coef_busy | (coef_idx > 4'd8));
            // Only a visible change strobes the datapath, not every frame start.
            swap_pulse <= (fs & (mode_next != mode_sel)) | (kernel_swap & (shadow != kernel));
            if (fs) begin
                mode_sel  <= mode_next;
                frame_cnt <= frame_cnt_next;
            end
            if (kernel_swap)
                kernel <= shadow;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    if (wr_ok && coef_idx == 4'(r * 3 + c))
                        shadow[r[1:0]][c[1:0]] <= coef_val;
            // A commit seen in the fs cycle itself waits for the following frame start.
            state <= coef_busy ? (fs ? IDLE : PENDING) : (coef_commit ? PENDING : IDLE);
        end
    end
endmodule

// File: tb/tb_filter_frame_scheduler.sv
// tb_filter_frame_scheduler: directed scenarios then randomized traffic, every cycle
// compared against a frame-level reference model of the scheduler.
module tb_filter_frame_scheduler;
    localparam int NM  = 15;
    localparam int P   = 16;
    localparam int FPM = 2;

    logic                   VGA_CLK = 1'b0;
    logic                   reset, iVGA_VS, auto_en, coef_wr, coef_commit;
    logic [3:0]             mode_req, coef_idx, mode_sel;
    logic [P-1:0]           coef_val;
    logic [2:0][2:0][P-1:0] kernel;
    logic                   coef_busy, swap_pulse, coef_err;

    int errors = 0;
    int checks = 0;
    int ph = 0;

    logic [P-1:0] m_shadow[9];
    logic [P-1:0] m_kernel[9];
    logic [3:0]   m_mode;
    int           m_frames;
    bit           m_pending, m_swap, m_err, m_fs;
    bit           vs_log[$];

    filter_frame_scheduler #(.NUM_MODES(NM), .PRECISION(P), .FRAMES_PER_MODE(FPM)) dut (
        .VGA_CLK(VGA_CLK), .reset(reset), .iVGA_VS(iVGA_VS), .mode_req(mode_req),
        .auto_en(auto_en), .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_val(coef_val),
        .coef_commit(coef_commit), .mode_sel(mode_sel), .kernel(kernel),
        .coef_busy(coef_busy), .swap_pulse(swap_pulse), .coef_err(coef_err)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9*P-1:0] model_kernel();
        logic [9*P-1:0] k;
        for (int i = 0; i < 9; i++) k[i*P +: P] = m_kernel[i];
        return k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_shadow[i] = '0;
            m_kernel[i] = '0;
        end
        m_mode = 4'd0;
        m_frames = 0;
        m_pending = 0;
        m_swap = 0;
        m_err = 0;
        vs_log = '{1'b1, 1'b1};
    endtask

    task automatic model_edge();
        logic [3:0] nm;
        bit was_pending, kchg;
        m_fs = 0;
        if (reset) begin
            model_reset();
            return;
        end
        m_fs = vs_log[0] && !vs_log[1];
        vs_log.push_back(iVGA_VS);
        void'(vs_log.pop_front());
        was_pending = m_pending;
        m_err = coef_wr && (was_pending || coef_idx > 8);
        m_swap = 0;
        if (m_fs) begin
            nm = m_mode;
            if (!auto_en) begin
                nm = (int'(mode_req) < NM) ? mode_req : 4'd0;
                m_frames = 0;
            end else begin
                m_frames++;
                if (m_frames == FPM) begin
                    m_frames = 0;
                    nm = 4'((int'(m_mode) + 1) % NM);
                end
            end
            kchg = 0;
            if (was_pending) begin
                for (int i = 0; i < 9; i++) begin
                    if (m_kernel[i] != m_shadow[i]) kchg = 1;
                    m_kernel[i] = m_shadow[i];
                end
                m_pending = 0;
            end
            m_swap = (nm != m_mode) || kchg;
            m_mode = nm;
        end
        if (!was_pending) begin
            if (coef_wr && coef_idx <= 8) m_shadow[coef_idx] = coef_val;
            if (coef_commit) m_pending = 1;
        end
    endtask

    task automatic tick();
        iVGA_VS = (ph % 220) < 200;
        ph++;
        @(posedge VGA_CLK);
        model_edge();
        @(negedge VGA_CLK);
        check("mode_sel", mode_sel, m_mode);
        check("kernel", kernel, model_kernel());
        check("coef_busy", coef_busy, m_pending);
        check("swap_pulse", swap_pulse, m_swap);
        check("coef_err", coef_err, m_err);
        coef_wr = 0;
        coef_commit = 0;
    endtask

    task automatic run_to_frame();
        for (int n = 0; n < 300; n++) begin
            tick();
            if (m_fs) return;
        end
        checks++;
        errors++;
        $display("FAIL frame_timeout: no frame start within 300 cycles");
    endtask

    task automatic to_fs_cycle();
        for (int n = 0; n < 300; n++) begin
            if (vs_log[0] && !vs_log[1]) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL fs_timeout: no frame start within 300 cycles");
    endtask

    initial begin
        logic [3:0] seq[4];
        seq = '{4'd13, 4'd14, 4'd14, 4'd0};
        reset = 1; iVGA_VS = 1; mode_req = 0; auto_en = 0;
        coef_wr = 0; coef_idx = 0; coef_val = 0; coef_commit = 0;
        model_reset();
        repeat (3) tick();
        check("rst_mode", mode_sel, 0);
        check("rst_kernel", kernel, 0);
        check("rst_busy", coef_busy, 0);
        check("rst_swap", swap_pulse, 0);
        check("rst_err", coef_err, 0);

        reset = 0; mode_req = 5;
        tick();
        check("mode_before_fs", mode_sel, 0);
        run_to_frame();
        check("mode_at_fs", mode_sel, 5);
        check("swap_mode", swap_pulse, 1);
        tick();
        check("swap_one_cycle", swap_pulse, 0);

        for (int i = 0; i < 9; i++) begin
            coef_wr = 1; coef_idx = 4'(i); coef_val = (i == 4) ? 16'd8 : 16'hFFFF;
            tick();
        end
        coef_commit = 1;
        tick();
        check("busy_on_commit", coef_busy, 1);
        check("kernel_held", kernel, 0);
        run_to_frame();
        check("k11", kernel[1][1], 16'd8);
        check("k00", kernel[0][0], 16'hFFFF);
        check("k22", kernel[2][2], 16'hFFFF);
        check("swap_kernel", swap_pulse, 1);
        check("busy_clear", coef_busy, 0);

        coef_commit = 1;
        tick();
        coef_wr = 1; coef_idx = 0; coef_val = 16'd3;
        tick();
        check("err_pending", coef_err, 1);
        tick();
        check("err_one_cycle", coef_err, 0);
        run_to_frame();
        check("k00_kept", kernel[0][0], 16'hFFFF);
        check("no_swap_same", swap_pulse, 0);
        coef_wr = 1; coef_idx = 9; coef_val = 16'h1234;
        tick();
        check("err_idx9", coef_err, 1);

        mode_req = 13;
        run_to_frame();
        check("mode13", mode_sel, 13);
        auto_en = 1;
        for (int i = 0; i < 4; i++) begin
            run_to_frame();
            check("auto_seq", mode_sel, seq[i]);
        end

        auto_en = 0; mode_req = 15;
        coef_wr = 1; coef_idx = 0; coef_val = 16'd7;
        tick();
        to_fs_cycle();
        coef_commit = 1;
        tick();
        check("mode_invalid", mode_sel, 0);
        check("coincident_no_xfer", kernel[0][0], 16'hFFFF);
        check("coincident_busy", coef_busy, 1);
        run_to_frame();
        check("coincident_xfer", kernel[0][0], 16'd7);

        coef_wr = 1; coef_idx = 8; coef_val = 16'd5;
        tick();
        coef_commit = 1;
        tick();
        check("busy_before_rst", coef_busy, 1);
        reset = 1;
        tick();
        check("rst_kernel_zero", kernel, 0);
        check("rst_busy_clear", coef_busy, 0);
        check("rst_no_swap", swap_pulse, 0);
        reset = 0;

        for (int n = 0; n < 8000; n++) begin
            reset = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 49) == 0) mode_req = 4'($urandom_range(0, 15));
            coef_wr = ($urandom_range(0, 7) == 0);
            coef_idx = 4'($urandom_range(0, 15));
            coef_val = 16'($urandom);
            coef_commit = ($urandom_range(0, 59) == 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
